pc_ctrl: RTL and testbench

- Parametrised program-counter unit for the IF stage. Successor to the single-IRQ PC register.
- Adds multi-line masked interrupts with fixed priority and optional vectoring.
- Adds an internal EPC/cause register pair and a two-state RUN/HANDLER machine that blocks nesting.
- Raises a misaligned-fetch exception. Sits between next-PC logic and instruction memory.

---
 rtl/pc_ctrl.sv | 131 +++++++++++++
 tb/tb_pc_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter unit for the IF stage.
// It has masked, fixed-priority interrupts with optional vectoring, an
// EPC/cause pair, and a RUN/HANDLER machine that forbids nesting.
// It also raises a misaligned-fetch exception when npc is not word aligned.
// The FSM state is visible as in_handler (1 = HANDLER).
module pc_ctrl #(
    parameter int            AW         = 32,
    parameter logic [AW-1:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [AW-1:0] EXC_BASE   = 32'h0000_4180,
    parameter int            NIRQ       = 6,
    parameter int            VECTORED   = 0,
    parameter int            VEC_SHIFT  = 4,
    localparam int           CW         = $clog2(NIRQ + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [AW-1:0]   npc,
    input  logic [AW-1:0]   epc_src,
    input  logic [NIRQ-1:0] irq_req,
    input  logic [NIRQ-1:0] irq_mask,
    input  logic            eret,
    output logic [AW-1:0]   pc,
    output logic [AW-1:0]   epc,
    output logic [CW-1:0]   cause,
    output logic            in_handler,
    output logic [NIRQ-1:0] irq_ack,
    output logic            misalign
);

    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    // Cause code reserved for the misaligned-fetch exception.
    localparam logic [CW-1:0] CAUSE_MISALIGN = CW'(NIRQ);

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_d, epc_d;
    logic [CW-1:0]   cause_d;
    logic [NIRQ-1:0] ack_d;
    logic            misalign_d;

    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] sel_oh;
    logic [CW-1:0]   sel;

    // Handler entry: a single base, or one slot per cause when vectored.
    function automatic logic [AW-1:0] entry_addr(input logic [CW-1:0] c);
        if (VECTORED != 0) begin
            return EXC_BASE + (AW'(c) << VEC_SHIFT);
        end
        return EXC_BASE;
    endfunction

    assign pend       = irq_req & irq_mask;
    // Isolate the lowest set bit, because index 0 has the highest priority.
    assign sel_oh     = pend & (~pend + NIRQ'(1));
    assign in_handler = (state_q == HANDLER);

    // Encode the one-hot winner into its line index.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (sel_oh[i]) sel = CW'(i);
        end
    end

    // Next-state, next-PC and pulse generation; the first matching rule wins.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        epc_d      = epc;
        cause_d    = cause;
        ack_d      = '0;
        misalign_d = 1'b0;
        case (state_q)
            RUN: begin
                if (pend != '0) begin
                    pc_d    = entry_addr(sel);
                    epc_d   = epc_src;
                    cause_d = sel;
                    ack_d   = sel_oh;
                    state_d = HANDLER;
                end else if (stall) begin
                    pc_d = pc;
                end else if (npc[1:0] != 2'b00) begin
                    pc_d       = entry_addr(CAUSE_MISALIGN);
                    epc_d      = npc;
                    cause_d    = CAUSE_MISALIGN;
                    misalign_d = 1'b1;
                    state_d    = HANDLER;
                end else begin
                    pc_d = npc;
                end
            end
            HANDLER: begin
                // Requests are ignored here; they are taken after the return.
                if (eret) begin
                    pc_d    = epc;
                    state_d = RUN;
                end else if (stall) begin
                    pc_d = pc;
                end else begin
                    // A misaligned npc is followed but only flagged.
                    pc_d       = npc;
                    misalign_d = (npc[1:0] != 2'b00);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State and output registers; reset is asynchronous and discards context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            pc       <= RESET_ADDR;
            epc      <= '0;
            cause    <= '0;
            irq_ack  <= '0;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            epc      <= epc_d;
            cause    <= cause_d;
            irq_ack  <= ack_d;
            misalign <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: a non-vectored and a vectored instance share all inputs.
// A behavioural model predicts both instances. Directed steps are followed by random traffic.
module tb_pc_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] npc;
    logic [31:0] epc_src;
    logic [5:0]  irq_req;
    logic [5:0]  irq_mask;
    logic        eret;

    logic [31:0] pc0, epc0, pc1, epc1;
    logic [2:0]  cause0, cause1;
    logic        inh0, inh1, mis0, mis1;
    logic [5:0]  ack0, ack1;

    int checks;
    int failures;

    // Model state, one entry per instance (0 = non-vectored, 1 = vectored).
    logic [31:0] m_pc[2];
    logic [31:0] m_epc[2];
    int          m_cause[2];
    bit          m_inh[2];
    logic [5:0]  m_ack[2];
    bit          m_mis[2];

    pc_ctrl #(.VECTORED(0)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .npc(npc), .epc_src(epc_src),
        .irq_req(irq_req), .irq_mask(irq_mask), .eret(eret),
        .pc(pc0), .epc(epc0), .cause(cause0), .in_handler(inh0),
        .irq_ack(ack0), .misalign(mis0)
    );

    pc_ctrl #(.VECTORED(1)) u_vec (
        .clk(clk), .reset(reset), .stall(stall), .npc(npc), .epc_src(epc_src),
        .irq_req(irq_req), .irq_mask(irq_mask), .eret(eret),
        .pc(pc1), .epc(epc1), .cause(cause1), .in_handler(inh1),
        .irq_ack(ack1), .misalign(mis1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] entry(input int k, input int c);
        return (k == 0) ? 32'h4180 : 32'h4180 + 32'(c * 16);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h3000; m_epc[k] = '0; m_cause[k] = 0;
            m_inh[k] = 0; m_ack[k] = '0; m_mis[k] = 0;
        end
    endtask

    // One clock edge of the architectural rules.
    task automatic model_step();
        logic [5:0] pend;
        int sel;
        pend = irq_req & irq_mask;
        sel = -1;
        for (int i = 5; i >= 0; i--) if (pend[i]) sel = i;
        for (int k = 0; k < 2; k++) begin
            m_ack[k] = '0;
            m_mis[k] = 0;
            if (!m_inh[k]) begin
                if (sel >= 0) begin
                    m_pc[k] = entry(k, sel); m_epc[k] = epc_src; m_cause[k] = sel;
                    m_ack[k] = 6'(1 << sel); m_inh[k] = 1;
                end else if (stall) begin
                end else if (npc % 4 != 0) begin
                    m_pc[k] = entry(k, 6); m_epc[k] = npc; m_cause[k] = 6;
                    m_mis[k] = 1; m_inh[k] = 1;
                end else begin
                    m_pc[k] = npc;
                end
            end else begin
                if (eret) begin
                    m_pc[k] = m_epc[k]; m_inh[k] = 0;
                end else if (stall) begin
                end else begin
                    m_pc[k] = npc;
                    m_mis[k] = (npc % 4 != 0);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, " u0.pc"},    pc0,           m_pc[0]);
        check({where, " u0.epc"},   epc0,          m_epc[0]);
        check({where, " u0.cause"}, 32'(cause0),   32'(m_cause[0]));
        check({where, " u0.inh"},   32'(inh0),     32'(m_inh[0]));
        check({where, " u0.ack"},   32'(ack0),     32'(m_ack[0]));
        check({where, " u0.mis"},   32'(mis0),     32'(m_mis[0]));
        check({where, " u1.pc"},    pc1,           m_pc[1]);
        check({where, " u1.epc"},   epc1,          m_epc[1]);
        check({where, " u1.cause"}, 32'(cause1),   32'(m_cause[1]));
        check({where, " u1.inh"},   32'(inh1),     32'(m_inh[1]));
        check({where, " u1.ack"},   32'(ack1),     32'(m_ack[1]));
        check({where, " u1.mis"},   32'(mis1),     32'(m_mis[1]));
    endtask

    // Advance one edge, update the model, sample #1 later.
    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
    endtask

    task automatic idle_inputs();
        stall = 0; eret = 0; irq_req = '0; irq_mask = 6'b111111; epc_src = '0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        idle_inputs();
        npc = 32'h3004;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        check("reset.pc_const", pc0, 32'h3000);
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch.
        npc = 32'h3004; cycle("seq1");
        check("seq1.pc_const", pc0, 32'h3004);
        npc = 32'h3008; cycle("seq2");
        check("seq2.pc_const", pc0, 32'h3008);
        npc = 32'h300C; cycle("seq3");
        npc = 32'h3010; cycle("seq4");

        // IRQ beats stall.
        stall = 1; irq_req = 6'b000100; epc_src = 32'h3010; npc = 32'h3014;
        cycle("irq_vs_stall");
        check("irq_vs_stall.pc_const", pc0, 32'h4180);
        check("irq_vs_stall.ack_const", 32'(ack0), 32'h4);
        stall = 0; irq_req = '0; npc = 32'h4184;
        cycle("ack_drop");
        eret = 1; cycle("eret1");
        eret = 0; npc = 32'h3014; cycle("run_again");

        // Priority and mask, vectored entry.
        irq_req = 6'b101010; irq_mask = 6'b101000; epc_src = 32'h3018;
        cycle("prio_mask");
        check("prio_mask.vec_pc_const", pc1, 32'h41B0);
        check("prio_mask.cause_const", 32'(cause1), 32'd3);

        // No nesting; eret beats stall; pending line re-enters after one cycle.
        irq_req = 6'b000001; irq_mask = 6'b111111; npc = 32'h41B4;
        cycle("no_nest");
        eret = 1; stall = 1;
        cycle("eret_stall");
        check("eret_stall.pc_const", pc0, 32'h3018);
        eret = 0; stall = 0;
        cycle("reenter");
        check("reenter.pc_const", pc0, 32'h4180);
        irq_req = '0; eret = 1; cycle("eret2");
        eret = 0;

        // Misaligned fetch in RUN, then in HANDLER.
        npc = 32'h3006; cycle("mis_run");
        check("mis_run.epc_const", epc0, 32'h3006);
        check("mis_run.vec_pc_const", pc1, 32'h41E0);
        cycle("mis_handler");
        check("mis_handler.pc_const", pc0, 32'h3006);
        npc = 32'h3008; cycle("mis_gone");

        // Asynchronous reset in the middle of a handler.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        npc = 32'h3004;
        cycle("post_reset");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            stall    = ($urandom_range(0, 3) == 0);
            eret     = ($urandom_range(0, 4) == 0);
            irq_req  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'b0;
            irq_mask = 6'($urandom);
            epc_src  = $urandom;
            npc      = $urandom;
            if ($urandom_range(0, 5) != 0) npc[1:0] = 2'b00;
            cycle($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
